// File: rtl/alu_op_sequencer.sv
// Issues one ALU command at a time: drives select/operands, waits SETTLE_CYCLES, captures the
// selected result with flags, and returns it over a valid/ready handshake.
module alu_op_sequencer #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,

    output logic [3:0]       alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_x,

    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             res_neg,
    output logic             res_err,
    output logic [7:0]       ops_done
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // Out-of-range settle values are pulled into 1..15 so the 4-bit counter cannot wrap.
    localparam int unsigned SettleLegal = (SETTLE_CYCLES < 1)  ? 1  :
                                          (SETTLE_CYCLES > 15) ? 15 : SETTLE_CYCLES;
    localparam logic [3:0]  CntInit     = 4'(SettleLegal - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic [3:0]       alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_zero_q, res_zero_d;
    logic             res_neg_q, res_neg_d;
    logic             res_err_q, res_err_d;
    logic [7:0]       ops_done_q, ops_done_d;

    logic accept;
    logic res_fire;
    logic op_illegal;

    assign accept     = cmd_valid & cmd_ready_q;
    assign res_fire   = res_valid_q & res_ready;
    assign op_illegal = (cmd_op == 4'b1101) | (cmd_op == 4'b1110);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_ready_d = cmd_ready_q;
        alu_sel_d   = alu_sel_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_zero_d  = res_zero_q;
        res_neg_d   = res_neg_q;
        res_err_d   = res_err_q;
        ops_done_d  = ops_done_q;

        unique case (state_q)
            StIdle: begin
                cmd_ready_d = 1'b1;
                res_valid_d = 1'b0;
                alu_sel_d   = 4'b0000;
                alu_a_d     = '0;
                alu_b_d     = '0;
                if (accept) begin
                    cmd_ready_d = 1'b0;
                    if (op_illegal) begin
                        // Illegal codes never reach the ALU; the error result is fixed.
                        state_d    = StDone;
                        res_data_d = '0;
                        res_zero_d = 1'b1;
                        res_neg_d  = 1'b0;
                        res_err_d  = 1'b1;
                    end else begin
                        state_d   = StWait;
                        cnt_d     = CntInit;
                        alu_sel_d = cmd_op;
                        alu_a_d   = cmd_a;
                        alu_b_d   = cmd_b;
                    end
                end
            end

            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d    = StDone;
                    res_data_d = alu_x;
                    res_zero_d = (alu_x == '0);
                    res_neg_d  = alu_x[WIDTH-1];
                    res_err_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            StDone: begin
                // res_valid follows the state by one edge, like every other registered output.
                res_valid_d = 1'b1;
                if (res_fire) begin
                    state_d     = StIdle;
                    res_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    alu_sel_d   = 4'b0000;
                    alu_a_d     = '0;
                    alu_b_d     = '0;
                    ops_done_d  = ops_done_q + 8'd1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            cmd_ready_q <= 1'b0;
            alu_sel_q   <= 4'b0000;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b0;
            res_neg_q   <= 1'b0;
            res_err_q   <= 1'b0;
            ops_done_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            alu_sel_q   <= alu_sel_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_zero_q  <= res_zero_d;
            res_neg_q   <= res_neg_d;
            res_err_q   <= res_err_d;
            ops_done_q  <= ops_done_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign alu_sel   = alu_sel_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_zero  = res_zero_q;
    assign res_neg   = res_neg_q;
    assign res_err   = res_err_q;
    assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (settle 1 and 3), each fed by a behavioural ALU,
// driven by a vector table, hand-written corner sequences and random commands.
module tb_alu_op_sequencer;

    localparam int unsigned W  = 8;
    localparam int unsigned S0 = 1;
    localparam int unsigned S1 = 3;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid [2];
    logic         cmd_ready [2];
    logic [3:0]   cmd_op    [2];
    logic [W-1:0] cmd_a     [2];
    logic [W-1:0] cmd_b     [2];
    logic [3:0]   alu_sel   [2];
    logic [W-1:0] alu_a     [2];
    logic [W-1:0] alu_b     [2];
    logic [W-1:0] alu_x     [2];
    logic         res_valid [2];
    logic         res_ready [2];
    logic [W-1:0] res_data  [2];
    logic         res_zero  [2];
    logic         res_neg   [2];
    logic         res_err   [2];
    logic [7:0]   ops_done  [2];

    int n_cmp = 0;
    int n_bad = 0;
    int exp_ops [2];

    typedef struct {
        int         u;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        int         hold;
        bit         early;
        logic [7:0] d;
        bit         z;
        bit         n;
        bit         e;
    } vec_t;

    vec_t tbl [8];

    alu_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
        .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]),
        .alu_sel(alu_sel[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_x(alu_x[0]),
        .res_valid(res_valid[0]), .res_ready(res_ready[0]), .res_data(res_data[0]),
        .res_zero(res_zero[0]), .res_neg(res_neg[0]), .res_err(res_err[0]),
        .ops_done(ops_done[0])
    );

    alu_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
        .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]),
        .alu_sel(alu_sel[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_x(alu_x[1]),
        .res_valid(res_valid[1]), .res_ready(res_ready[1]), .res_data(res_data[1]),
        .res_zero(res_zero[1]), .res_neg(res_neg[1]), .res_err(res_err[1]),
        .ops_done(ops_done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Illegal codes return a non-zero marker so a sequencer that drives them is caught.
    function automatic logic [W-1:0] alu_fn(input logic [3:0] sel, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (sel)
            4'b0000: return '0;
            4'b0001: return a;
            4'b0010: return b;
            4'b0011: return ~a;
            4'b0100: return ~b;
            4'b0101: return a & b;
            4'b0110: return a | b;
            4'b0111: return a ^ b;
            4'b1000: return a << 1;
            4'b1001: return a >> 1;
            4'b1010: return b << 1;
            4'b1011: return a - b;
            4'b1100: return a + b;
            4'b1111: return '1;
            default: return 8'h5A;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < 2; i++) alu_x[i] = alu_fn(alu_sel[i], alu_a[i], alu_b[i]);
    end

    function automatic int s_of(input int u);
        return (u == 0) ? int'(S0) : int'(S1);
    endfunction

    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] d, output bit z, output bit n, output bit e);
        e = (op == 4'b1101) || (op == 4'b1110);
        d = e ? '0 : alu_fn(op, a, b);
        z = (d == '0);
        n = d[W-1];
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] outs(input int u);
        logic [63:0] v;
        v = '0;
        v[40:0] = {cmd_ready[u], alu_sel[u], alu_a[u], alu_b[u], res_valid[u], res_data[u],
                   res_zero[u], res_neg[u], res_err[u], ops_done[u]};
        return v;
    endfunction

    // One full transaction on instance u. Entered between clock edges.
    task automatic run_op(input int u, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int hold, input bit early,
                          input logic [W-1:0] e_data, input bit e_zero, input bit e_neg,
                          input bit e_err, input bit offer, input logic [3:0] p_op,
                          input logic [W-1:0] p_a, input logic [W-1:0] p_b,
                          output int waited);
        int           lat;
        int           exp_lat;
        bit           ok;
        bit           illegal;
        logic [3:0]   e_sel;
        logic [W-1:0] e_a;
        logic [W-1:0] e_b;

        illegal = (op == 4'b1101) || (op == 4'b1110);
        e_sel   = illegal ? 4'b0000 : op;
        e_a     = illegal ? '0 : a;
        e_b     = illegal ? '0 : b;
        exp_lat = illegal ? 1 : s_of(u) + 1;

        cmd_valid[u] = 1'b1;
        cmd_op[u]    = op;
        cmd_a[u]     = a;
        cmd_b[u]     = b;
        res_ready[u] = early;
        waited = 0;
        while (!cmd_ready[u] && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check("cmd_accept", cmd_ready[u], 1'b1);
        if (!cmd_ready[u]) begin
            cmd_valid[u] = 1'b0;
            res_ready[u] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        cmd_valid[u] = 1'b0;
        cmd_op[u]    = 4'($urandom);
        cmd_a[u]     = W'($urandom);
        cmd_b[u]     = W'($urandom);

        lat = 0;
        ok  = 1'b1;
        @(negedge clk);
        while (!res_valid[u] && lat < 40) begin
            if (alu_sel[u] !== e_sel || alu_a[u] !== e_a || alu_b[u] !== e_b ||
                ops_done[u] !== exp_ops[u] || cmd_ready[u] !== 1'b0) ok = 1'b0;
            cmd_valid[u] = 1'($urandom);
            cmd_op[u]    = 4'($urandom);
            cmd_a[u]     = W'($urandom);
            @(negedge clk);
            lat++;
        end
        cmd_valid[u] = 1'b0;
        check("latency", lat, exp_lat);
        if (!res_valid[u]) begin
            res_ready[u] = 1'b0;
            return;
        end
        check("alu_drive_while_busy", ok, 1'b1);
        check("res_data", res_data[u], e_data);
        check("res_flags", {res_zero[u], res_neg[u], res_err[u]}, {e_zero, e_neg, e_err});
        check("alu_in_done", {alu_sel[u], alu_a[u], alu_b[u]}, {e_sel, e_a, e_b});
        check("cmd_ready_in_done", cmd_ready[u], 1'b0);

        if (!early) begin
            ok = 1'b1;
            if (offer) begin
                cmd_valid[u] = 1'b1;
                cmd_op[u]    = p_op;
                cmd_a[u]     = p_a;
                cmd_b[u]     = p_b;
            end
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (res_valid[u] !== 1'b1 || res_data[u] !== e_data ||
                    {res_zero[u], res_neg[u], res_err[u]} !== {e_zero, e_neg, e_err} ||
                    {alu_sel[u], alu_a[u], alu_b[u]} !== {e_sel, e_a, e_b} ||
                    cmd_ready[u] !== 1'b0 || ops_done[u] !== exp_ops[u]) ok = 1'b0;
            end
            check("backpressure_stable", ok, 1'b1);
            res_ready[u] = 1'b1;
        end
        @(negedge clk);
        res_ready[u] = 1'b0;
        exp_ops[u] = (exp_ops[u] + 1) % 256;
        check("ops_done", ops_done[u], exp_ops[u]);
        check("res_valid_clear", res_valid[u], 1'b0);
        check("cmd_ready_back", cmd_ready[u], 1'b1);
        check("alu_cleared", {alu_sel[u], alu_a[u], alu_b[u]}, 20'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           waited;
        bit           ok;
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        bit           z;
        bit           n;
        bit           e;

        tbl[0] = '{0, 4'b1100, 8'h05, 8'h03, 0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{0, 4'b0000, 8'h5A, 8'hC3, 0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{0, 4'b1111, 8'h12, 8'h34, 2, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{0, 4'b1101, 8'h05, 8'h03, 0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1, 4'b1110, 8'hFF, 8'hFF, 0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1, 4'b1100, 8'h80, 8'h7F, 0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1, 4'b1011, 8'h10, 8'h10, 1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1, 4'b0111, 8'hA5, 8'h0F, 0, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cmd_valid[i] = 1'b0;
            cmd_op[i]    = 4'h0;
            cmd_a[i]     = '0;
            cmd_b[i]     = '0;
            res_ready[i] = 1'b0;
            exp_ops[i]   = 0;
        end

        // Reset and release.
        repeat (3) @(negedge clk);
        check("reset_outs_0", outs(0), 64'h0);
        check("reset_outs_1", outs(1), 64'h0);
        rst_n = 1'b1;
        #1;
        check("ready_before_first_edge", cmd_ready[0], 1'b0);
        @(negedge clk);
        check("ready_after_release_0", cmd_ready[0], 1'b1);
        check("ready_after_release_1", cmd_ready[1], 1'b1);
        check("no_valid_after_release", {res_valid[0], res_valid[1]}, 2'b00);

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].u, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hold, tbl[i].early,
                   tbl[i].d, tbl[i].z, tbl[i].n, tbl[i].e, 1'b0, 4'h0, 8'h00, 8'h00, waited);
        end

        // Backpressure with a pending command that must be taken right after the handshake.
        run_op(1, 4'b1100, 8'h20, 8'h22, 5, 1'b0, 8'h42, 1'b0, 1'b0, 1'b0,
               1'b1, 4'b0001, 8'h3C, 8'h00, waited);
        run_op(1, 4'b0001, 8'h3C, 8'h00, 0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0,
               1'b0, 4'h0, 8'h00, 8'h00, waited);
        check("pending_taken_at_once", waited, 0);

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = W'($urandom);
            b  = W'($urandom);
            model(op, a, b, d, z, n, e);
            run_op(1, op, a, b, int'($urandom_range(0, 3)), 1'($urandom), d, z, n, e,
                   1'b0, 4'h0, 8'h00, 8'h00, waited);
        end

        // Reset in the middle of WAIT discards the op.
        cmd_valid[1] = 1'b1;
        cmd_op[1]    = 4'b1100;
        cmd_a[1]     = 8'h01;
        cmd_b[1]     = 8'h01;
        @(posedge clk);
        #1;
        cmd_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        check("mid_wait_alu_sel", alu_sel[1], 4'b1100);
        rst_n = 1'b0;
        #1;
        check("mid_wait_reset_outs_1", outs(1), 64'h0);
        check("mid_wait_reset_outs_0", outs(0), 64'h0);
        exp_ops[0] = 0;
        exp_ops[1] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid[1] !== 1'b0 || cmd_ready[1] !== 1'b1 || ops_done[1] !== 8'h00) ok = 1'b0;
        end
        check("no_result_after_mid_reset", ok, 1'b1);

        for (int i = 0; i < 256; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = W'($urandom);
            b  = W'($urandom);
            model(op, a, b, d, z, n, e);
            run_op(0, op, a, b, 0, 1'b1, d, z, n, e, 1'b0, 4'h0, 8'h00, 8'h00, waited);
            if (i == 254) check("ops_done_255", ops_done[0], 8'hFF);
        end
        check("ops_done_wrap", ops_done[0], 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
